// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder types: colour component and MCU scheduler state encodings,
// plus the fixed 8x8 block length.
package jpeg_enc_pkg;

    localparam int BLK_BEATS = 64;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    typedef enum logic [1:0] {
        ST_Y  = 2'd0,
        ST_CB = 2'd1,
        ST_CR = 2'd2
    } sched_state_t;

    // The component tag follows the state one-for-one.
    function automatic comp_t state_comp(sched_state_t s);
        case (s)
            ST_CB:   return COMP_CB;
            ST_CR:   return COMP_CR;
            default: return COMP_Y;
        endcase
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int KEEP_W = (DATA_WIDTH + 7) / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]     tstrb;
    logic [KEEP_W-1:0]     tkeep;
    logic                  tlast;
    logic                  tuser;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/mcu_scheduler.sv
// Interleaves Y/Cb/Cr 8x8 blocks into one stream for the shared DCT pipeline.
// 4:2:0 support (four Y blocks per MCU) is built only with MCU_SCHED_SUBSAMPLE_EN.
module mcu_scheduler
    import jpeg_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BLK_BEATS  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    axi4_stream_if.slave         y_i,
    axi4_stream_if.slave         cb_i,
    axi4_stream_if.slave         cr_i,
    axi4_stream_if.master        blk_o,
    output logic [1:0]           comp_o,
    input  logic                 mode_i,
    output logic                 err_o
);
    localparam int                BEAT_W    = $clog2(jpeg_enc_pkg::BLK_BEATS);
    localparam int                KEEP_W    = (DATA_WIDTH + 7) / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_BEATS - 1);

    sched_state_t          state_reg, state_next;
    logic [BEAT_W-1:0]     beat_reg;
    logic                  err_reg;
    logic                  sel_valid, sel_last, xfer, last_beat, first_y;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  unused_in;

`ifdef MCU_SCHED_SUBSAMPLE_EN
    logic [1:0] y_blk_cnt_reg;
    logic       mode_q_reg;
    logic       y_done;

    assign first_y   = (state_reg == ST_Y) && (y_blk_cnt_reg == 2'd0);
    assign y_done    = !mode_q_reg || (y_blk_cnt_reg == 2'd3);
    assign unused_in = ^{y_i.tstrb, y_i.tkeep, cb_i.tstrb, cb_i.tkeep, cb_i.tuser,
                         cr_i.tstrb, cr_i.tkeep, cr_i.tuser};
`else
    assign first_y   = (state_reg == ST_Y);
    assign unused_in = ^{y_i.tstrb, y_i.tkeep, cb_i.tstrb, cb_i.tkeep, cb_i.tuser,
                         cr_i.tstrb, cr_i.tkeep, cr_i.tuser, mode_i};
`endif

    assign last_beat = (beat_reg == LAST_BEAT);
    assign comp_o    = state_comp(state_reg);
    assign err_o     = err_reg;

    // Zero-latency mux; reset gates every valid/ready so nothing moves while held.
    always_comb begin
        sel_valid   = 1'b0;
        sel_data    = '0;
        sel_last    = 1'b0;
        state_next  = state_reg;
        unique case (state_reg)
            ST_Y:    begin sel_valid = y_i.tvalid;  sel_data = y_i.tdata;  sel_last = y_i.tlast;  end
            ST_CB:   begin sel_valid = cb_i.tvalid; sel_data = cb_i.tdata; sel_last = cb_i.tlast; end
            ST_CR:   begin sel_valid = cr_i.tvalid; sel_data = cr_i.tdata; sel_last = cr_i.tlast; end
            default: ;
        endcase

        blk_o.tvalid = sel_valid & rst_n_i;
        blk_o.tdata  = sel_data;
        blk_o.tlast  = last_beat;
        blk_o.tuser  = first_y && (beat_reg == '0) && y_i.tuser;
        blk_o.tstrb  = {KEEP_W{1'b1}};
        blk_o.tkeep  = {KEEP_W{1'b1}};
        y_i.tready   = rst_n_i & blk_o.tready & (state_reg == ST_Y);
        cb_i.tready  = rst_n_i & blk_o.tready & (state_reg == ST_CB);
        cr_i.tready  = rst_n_i & blk_o.tready & (state_reg == ST_CR);
        xfer         = sel_valid & blk_o.tready & rst_n_i;

        if (xfer && last_beat) begin
            unique case (state_reg)
`ifdef MCU_SCHED_SUBSAMPLE_EN
                ST_Y:    state_next = y_done ? ST_CB : ST_Y;
`else
                ST_Y:    state_next = ST_CB;
`endif
                ST_CB:   state_next = ST_CR;
                ST_CR:   state_next = ST_Y;
                default: state_next = ST_Y;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= ST_Y;
        else          state_reg <= state_next;
    end

    // Beat counter wraps naturally at 64; framing errors are flagged but never stall.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_reg <= '0;
            err_reg  <= 1'b0;
        end else if (xfer) begin
            beat_reg <= beat_reg + 1'b1;
            if (sel_last != last_beat) err_reg <= 1'b1;
        end
    end

`ifdef MCU_SCHED_SUBSAMPLE_EN
    // Mode is frozen at the first beat of each MCU so a block group is never mixed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            y_blk_cnt_reg <= 2'd0;
            mode_q_reg    <= 1'b0;
        end else if (xfer) begin
            if (first_y && (beat_reg == '0)) mode_q_reg <= mode_i;
            if ((state_reg == ST_Y) && last_beat)
                y_blk_cnt_reg <= y_done ? 2'd0 : y_blk_cnt_reg + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcu_scheduler.sv
// Bench for mcu_scheduler: table of randomized runs against an MCU-level reference
// queue, plus directed framing-error and mid-block reset sequences.
module tb_mcu_scheduler;
    import jpeg_enc_pkg::*;

    localparam int DW = 8;
`ifdef MCU_SCHED_SUBSAMPLE_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode  = 1'b0;
    logic [1:0] comp;
    logic       err;

    axi4_stream_if #(.DATA_WIDTH(DW)) y_if  ();
    axi4_stream_if #(.DATA_WIDTH(DW)) cb_if ();
    axi4_stream_if #(.DATA_WIDTH(DW)) cr_if ();
    axi4_stream_if #(.DATA_WIDTH(DW)) blk_if();

    mcu_scheduler #(.DATA_WIDTH(DW), .BLK_BEATS(64)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .y_i    (y_if),
        .cb_i   (cb_if),
        .cr_i   (cr_if),
        .blk_o  (blk_if),
        .comp_o (comp),
        .mode_i (mode),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         src;
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        bit mode;
        int rdy_pct;
        int val_pct;
        int toggle_at;
        int exp_beats;
        int exp_lasts;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];
    int    m_idx[3];
    int    d_idx[3];
    bit    v[3];
    int    out_cnt;
    int    last_cnt;
    int    inject_cb_last = -1;
    vec_t  tbl[7];

    function automatic logic [7:0] src_data(int s, int i);
        return 8'(((i * 37) + (s * 91) + ((i / 64) * 13)) ^ (s * 32));
    endfunction

    function automatic logic src_last(int s, int i);
        return ((i % 64) == 63) || (s == 1 && i == inject_cb_last);
    endfunction

    function automatic logic y_user(int i);
        return (i % 128) == 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: one MCU = N Y blocks (1 or 4) then one Cb and one Cr block.
    task automatic gen_mcu(input bit m);
        beat_t e;
        int    nb = m ? 4 : 1;
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < 64; k++) begin
                e.src  = 0;
                e.data = src_data(0, m_idx[0]);
                e.last = (k == 63);
                e.user = (b == 0 && k == 0) ? y_user(m_idx[0]) : 1'b0;
                exp_q.push_back(e);
                m_idx[0]++;
            end
        for (int s = 1; s < 3; s++)
            for (int k = 0; k < 64; k++) begin
                e.src  = s;
                e.data = src_data(s, m_idx[s]);
                e.last = (k == 63);
                e.user = 1'b0;
                exp_q.push_back(e);
                m_idx[s]++;
            end
    endtask

    task automatic drive_src();
        y_if.tvalid  = v[0]; y_if.tdata  = src_data(0, d_idx[0]);
        y_if.tlast   = src_last(0, d_idx[0]); y_if.tuser = y_user(d_idx[0]);
        cb_if.tvalid = v[1]; cb_if.tdata = src_data(1, d_idx[1]);
        cb_if.tlast  = src_last(1, d_idx[1]); cb_if.tuser = 1'b0;
        cr_if.tvalid = v[2]; cr_if.tdata = src_data(2, d_idx[2]);
        cr_if.tlast  = src_last(2, d_idx[2]); cr_if.tuser = 1'b0;
        y_if.tstrb = '1;  y_if.tkeep = '1;
        cb_if.tstrb = '1; cb_if.tkeep = '1;
        cr_if.tstrb = '1; cr_if.tkeep = '1;
    endtask

    task automatic one_cycle(input int rdy_pct, input int val_pct);
        logic [2:0]  rdy, vld, hs, exp_rdy;
        logic [14:0] act, expv;
        int          es;
        beat_t       e;
        @(negedge clk);
        rdy     = {cr_if.tready, cb_if.tready, y_if.tready};
        vld     = {cr_if.tvalid, cb_if.tvalid, y_if.tvalid};
        hs      = rdy & vld;
        es      = (exp_q.size() > 0) ? exp_q[0].src : 0;
        exp_rdy = blk_if.tready ? 3'(1 << es) : 3'b000;
        check("src_ready", 32'(rdy), 32'(exp_rdy));
        if (blk_if.tvalid && blk_if.tready) begin
            if (exp_q.size() == 0) gen_mcu(mode & SUB);
            e    = exp_q.pop_front();
            act  = {hs, comp, blk_if.tlast, blk_if.tuser, blk_if.tdata};
            expv = {3'(1 << e.src), 2'(e.src), e.last, e.user, e.data};
            check($sformatf("beat%0d", out_cnt), 32'(act), 32'(expv));
            out_cnt++;
            if (blk_if.tlast) last_cnt++;
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) if (hs[s]) d_idx[s]++;
        for (int s = 0; s < 3; s++)
            if (!v[s] || hs[s]) v[s] = (int'($urandom_range(99)) < val_pct);
        blk_if.tready = (int'($urandom_range(99)) < rdy_pct);
        drive_src();
    endtask

    task automatic run_to(input int target, input int rdy, input int val, input int toggle_at);
        int cyc     = 0;
        bit toggled = 1'b0;
        while (out_cnt < target && cyc < target * 20 + 100) begin
            one_cycle(rdy, val);
            cyc++;
            if (!toggled && toggle_at >= 0 && out_cnt >= toggle_at) begin
                mode    = ~mode;
                toggled = 1'b1;
            end
        end
        if (out_cnt < target) check("timeout", 32'(out_cnt), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v = '{1'b1, 1'b1, 1'b1};
        blk_if.tready = 1'b1;
        drive_src();
        #1;
        check("reset_out", 32'({blk_if.tvalid, y_if.tready, cb_if.tready, cr_if.tready, comp, err}), 32'd0);
        repeat (3) @(posedge clk);
        exp_q.delete();
        for (int s = 0; s < 3; s++) begin m_idx[s] = 0; d_idx[s] = 0; end
        out_cnt = 0; last_cnt = 0; inject_cb_last = -1;
        v = '{1'b0, 1'b0, 1'b0};
        drive_src();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            mode  rdy  val  toggle beats                lasts
        tbl[0] = '{1'b0, 100, 100,  -1, 192,                 3};
        tbl[1] = '{1'b0,  70,  60,  -1, 576,                 9};
        tbl[2] = '{1'b1, 100, 100,  -1, SUB ? 384 : 192,     SUB ? 6 : 3};
        tbl[3] = '{1'b1,  70,  50,  -1, SUB ? 768 : 384,     SUB ? 12 : 6};
        tbl[4] = '{1'b1, 100,  80, 100, SUB ? 576 : 384,     SUB ? 9 : 6};
        tbl[5] = '{1'b0, 100,  80, 100, SUB ? 576 : 384,     SUB ? 9 : 6};
        tbl[6] = '{1'b0,  30,  70,  -1, 192,                 3};

        blk_if.tready = 1'b0;
        drive_src();

        foreach (tbl[i]) begin
            do_reset();
            mode = tbl[i].mode;
            run_to(tbl[i].exp_beats, tbl[i].rdy_pct, tbl[i].val_pct, tbl[i].toggle_at);
            check($sformatf("lasts_%0d", i), 32'(last_cnt), 32'(tbl[i].exp_lasts));
            check($sformatf("mcu_end_%0d", i), 32'(exp_q.size()), 32'd0);
            check($sformatf("err_clean_%0d", i), 32'(err), 32'd0);
        end

        // Cb tlast forced early at beat 40: error is sticky but the stream keeps its framing.
        do_reset();
        mode = 1'b0;
        inject_cb_last = 40;
        run_to(104, 100, 100, -1);
        check("err_before", 32'(err), 32'd0);
        run_to(105, 100, 100, -1);
        check("err_set", 32'(err), 32'd1);
        run_to(192, 100, 100, -1);
        check("err_sticky", 32'(err), 32'd1);
        check("err_mcu_end", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a Cb block.
        do_reset();
        mode = 1'b0;
        run_to(94, 100, 100, -1);
        check("pre_reset_comp", 32'(comp), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({blk_if.tvalid, cb_if.tready, comp, err}), 32'd0);
        do_reset();
        run_to(192, 100, 100, -1);
        check("post_reset_lasts", 32'(last_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
